// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined floating-point add/sub unit:
// default field widths, special-case tags, flag indices and the qNaN pattern.
package fp_pkg;

    localparam int FP_EXP_W    = 8;
    localparam int FP_MAN_W    = 23;
    localparam int FP_W        = 1 + FP_EXP_W + FP_MAN_W;
    localparam int FP_SIGN_BIT = FP_W - 1;
    localparam int FP_EXP_LSB  = FP_MAN_W;
    localparam int FP_EXP_MSB  = FP_W - 2;

    // Special-case outcome decided during alignment and carried down the pipe
    typedef enum logic [1:0] {
        TAG_NORMAL,
        TAG_ZERO,
        TAG_INF,
        TAG_QNAN
    } fp_tag_e;

    // Bit positions inside flags_o = {invalid, overflow, underflow, inexact}
    localparam int FLG_INX = 0;
    localparam int FLG_UDF = 1;
    localparam int FLG_OVF = 2;
    localparam int FLG_INV = 3;
    localparam int FLG_W   = 4;

    // Canonical quiet NaN: sign 0, exponent all ones, only the mantissa MSB set
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
        v[man_w - 1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fp_addsub_pipe_lzc.sv
// Leading-zero counter; an all-zero input reports IN_W.
module fp_lzc #(
    parameter  int IN_W  = 28,
    localparam int CNT_W = $clog2(IN_W + 1)
) (
    input  logic [IN_W-1:0]  i_data,
    output logic [CNT_W-1:0] o_cnt
);

    // Scan upward so the highest set bit is the last one to win
    always_comb begin
        o_cnt = CNT_W'(IN_W);
        for (int i = 0; i < IN_W; i++) begin
            if (i_data[i]) o_cnt = CNT_W'(IN_W - 1 - i);
        end
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point add/sub: align, add, normalise/round/pack.
// One global enable stalls every stage when the output is held.
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [EXP_W+MAN_W:0]     data_iA,
    input  logic [EXP_W+MAN_W:0]     data_iB,
    input  logic                     AddSub_Sel,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [EXP_W+MAN_W:0]     data_o,
    output logic [FLG_W-1:0]         flags_o
);

    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int SW     = MAN_W + 1;            // significand incl. hidden bit
    localparam int AW     = MAN_W + 4;            // plus guard/round/sticky
    localparam int NW     = MAN_W + 5;            // plus carry
    localparam int CW     = $clog2(NW + 1);
    localparam int XW     = EXP_W + 2;            // exponent workspace, two's complement
    localparam int STAGES = 3;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [EXP_W-1:0] SH_MAX  = EXP_W'(MAN_W + 3);
    localparam logic [W-1:0]     QNAN    = W'(fp_qnan(EXP_W, MAN_W));

    logic w_en, w_acc;
    logic [STAGES:1] r_vld_pipe;

    assign w_en    = ~valid_o | ready_i;
    assign ready_o = w_en;
    assign w_acc   = valid_i & w_en;
    assign valid_o = r_vld_pipe[STAGES];

    // ---------------- stage 1: classify, swap, align ----------------
    logic             w_sa, w_sb, w_a_ge;
    logic [EXP_W-1:0] w_ea, w_eb, w_big_e, w_small_e, w_diff;
    logic [MAN_W-1:0] w_ma, w_mb, w_big_m, w_small_m;
    logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic [SW-1:0]    w_big_sig, w_small_sig;
    logic [AW-1:0]    w_ext, w_small_al;
    fp_tag_e          w_tag;
    logic             w_s1_sign, w_s1_inv;

    assign w_sa     = data_iA[W-1];
    assign w_ea     = data_iA[W-2 -: EXP_W];
    assign w_ma     = data_iA[MAN_W-1:0];
    assign w_sb     = data_iB[W-1] ^ AddSub_Sel;
    assign w_eb     = data_iB[W-2 -: EXP_W];
    assign w_mb     = data_iB[MAN_W-1:0];
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (w_ea == EXP_MAX) && (w_ma == '0);
    assign w_b_inf  = (w_eb == EXP_MAX) && (w_mb == '0);
    assign w_a_nan  = (w_ea == EXP_MAX) && (w_ma != '0);
    assign w_b_nan  = (w_eb == EXP_MAX) && (w_mb != '0);

    // Order operands by magnitude, shift the smaller one keeping a sticky bit,
    // and decide special-value outcomes up front
    always_comb begin
        w_a_ge      = {w_ea, w_ma} >= {w_eb, w_mb};
        w_big_e     = w_a_ge ? w_ea : w_eb;
        w_big_m     = w_a_ge ? w_ma : w_mb;
        w_small_e   = w_a_ge ? w_eb : w_ea;
        w_small_m   = w_a_ge ? w_mb : w_ma;
        // exponent 0 means flushed to zero: no hidden bit, mantissa ignored
        w_big_sig   = (w_big_e == '0)   ? '0 : {1'b1, w_big_m};
        w_small_sig = (w_small_e == '0) ? '0 : {1'b1, w_small_m};
        w_diff      = w_big_e - w_small_e;
        w_ext       = {w_small_sig, 3'b000};
        if (w_diff >= SH_MAX)
            w_small_al = {{(AW-1){1'b0}}, |w_ext};
        else
            w_small_al = (w_ext >> w_diff) | AW'(|(w_ext & ~({AW{1'b1}} << w_diff)));

        w_tag     = TAG_NORMAL;
        w_s1_sign = w_a_ge ? w_sa : w_sb;
        w_s1_inv  = 1'b0;
        if (w_a_nan || w_b_nan) begin
            w_tag    = TAG_QNAN;
            w_s1_inv = (w_a_nan & ~w_ma[MAN_W-1]) | (w_b_nan & ~w_mb[MAN_W-1]);
        end else if (w_a_inf && w_b_inf) begin
            w_tag     = (w_sa != w_sb) ? TAG_QNAN : TAG_INF;
            w_s1_inv  = (w_sa != w_sb);
            w_s1_sign = w_sa;
        end else if (w_a_inf) begin
            w_tag     = TAG_INF;
            w_s1_sign = w_sa;
        end else if (w_b_inf) begin
            w_tag     = TAG_INF;
            w_s1_sign = w_sb;
        end else if (w_a_zero && w_b_zero) begin
            w_tag     = TAG_ZERO;
            w_s1_sign = w_sa & w_sb;
        end
    end

    fp_tag_e          r_s1_tag;
    logic             r_s1_sign, r_s1_inv, r_s1_sub;
    logic [EXP_W-1:0] r_s1_exp;
    logic [AW-1:0]    r_s1_big, r_s1_small;

    // Valid bits advance as a shift register; reset clears every slot
    always_ff @(posedge clk) begin
        if (rst)       r_vld_pipe <= '0;
        else if (w_en) r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_acc};
    end

    // Stage-1 register bank
    always_ff @(posedge clk) begin
        if (w_en) begin
            r_s1_tag   <= w_tag;
            r_s1_sign  <= w_s1_sign;
            r_s1_inv   <= w_s1_inv;
            r_s1_sub   <= w_sa ^ w_sb;
            r_s1_exp   <= w_big_e;
            r_s1_big   <= {w_big_sig, 3'b000};
            r_s1_small <= w_small_al;
        end
    end

    // ---------------- stage 2: magnitude add/subtract ----------------
    logic [NW-1:0] w_sum;
    assign w_sum = r_s1_sub ? ({1'b0, r_s1_big} - {1'b0, r_s1_small})
                            : ({1'b0, r_s1_big} + {1'b0, r_s1_small});

    fp_tag_e          r_s2_tag;
    logic             r_s2_sign, r_s2_inv;
    logic [EXP_W-1:0] r_s2_exp;
    logic [NW-1:0]    r_s2_sum;

    // Stage-2 register bank
    always_ff @(posedge clk) begin
        if (w_en) begin
            r_s2_tag  <= r_s1_tag;
            r_s2_sign <= r_s1_sign;
            r_s2_inv  <= r_s1_inv;
            r_s2_exp  <= r_s1_exp;
            r_s2_sum  <= w_sum;
        end
    end

    // ---------------- stage 3: normalise, round, pack ----------------
    logic [CW-1:0]    w_lz, w_lzm1;
    logic [NW-2:0]    w_shl, w_norm;
    logic [XW-1:0]    w_exp_x, w_e_norm, w_e_fin;
    logic             w_up, w_grs_nz;
    logic [SW:0]      w_mant_r;
    logic [MAN_W-1:0] w_frac;
    logic [W-1:0]     w_res;
    logic [FLG_W-1:0] w_flg;

    fp_lzc #(.IN_W(NW)) u_lzc (
        .i_data (r_s2_sum),
        .o_cnt  (w_lz)
    );

    // Hidden bit lands at the top of w_norm; carry-out shifts right, otherwise
    // shift left past the leading zeros above the hidden-bit position
    always_comb begin
        w_exp_x = {2'b00, r_s2_exp};
        w_lzm1  = w_lz - 1'b1;
        w_shl   = (NW-1)'(r_s2_sum << w_lzm1);
        if (r_s2_sum[NW-1]) begin
            w_norm   = {r_s2_sum[NW-1:2], r_s2_sum[1] | r_s2_sum[0]};
            w_e_norm = w_exp_x + XW'(1);
        end else begin
            w_norm   = w_shl;
            w_e_norm = w_exp_x - XW'(w_lzm1);
        end
        w_grs_nz = |w_norm[2:0];
        w_up     = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_mant_r = {1'b0, w_norm[AW-1:3]} + (SW+1)'(w_up);
        if (w_mant_r[SW]) begin
            w_frac  = w_mant_r[MAN_W:1];
            w_e_fin = w_e_norm + XW'(1);
        end else begin
            w_frac  = w_mant_r[MAN_W-1:0];
            w_e_fin = w_e_norm;
        end

        w_res = {r_s2_sign, w_e_fin[EXP_W-1:0], w_frac};
        w_flg = '0;
        w_flg[FLG_INX] = w_grs_nz;
        case (r_s2_tag)
            TAG_QNAN: begin
                w_res = QNAN;
                w_flg = '0;
                w_flg[FLG_INV] = r_s2_inv;
            end
            TAG_INF: begin
                w_res = {r_s2_sign, EXP_MAX, {MAN_W{1'b0}}};
                w_flg = '0;
            end
            TAG_ZERO: begin
                w_res = {r_s2_sign, {(W-1){1'b0}}};
                w_flg = '0;
            end
            default: begin
                if (r_s2_sum == '0) begin
                    // exact cancellation always yields +0
                    w_res = '0;
                    w_flg = '0;
                end else if (!w_e_fin[XW-1] && (w_e_fin[XW-2:0] >= (XW-1)'(EXP_MAX))) begin
                    w_res = {r_s2_sign, EXP_MAX, {MAN_W{1'b0}}};
                    w_flg[FLG_OVF] = 1'b1;
                    w_flg[FLG_INX] = 1'b1;
                end else if (w_e_fin[XW-1] || (w_e_fin == '0)) begin
                    w_res = {r_s2_sign, {(W-1){1'b0}}};
                    w_flg[FLG_UDF] = 1'b1;
                    w_flg[FLG_INX] = 1'b1;
                end
            end
        endcase
    end

    // Output register bank; holds while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            data_o  <= '0;
            flags_o <= '0;
        end else if (w_en) begin
            data_o  <= w_res;
            flags_o <= w_flg;
        end
    end

endmodule
